// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// MDU_MADD_EN enables the madd/msub family as engine ops.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MADD    = 4'd7,
        MADDU   = 4'd8,
        MSUB    = 4'd9,
        MSUBU   = 4'd10
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

    // Ops that occupy the engine and raise busy.
    function automatic logic is_engine_op(md_op_t op);
        case (op)
            MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(md_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface mult_div_unit_if;
    logic        md_valid;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output md_valid, md_op, rs_val, rt_val,
        input  busy, hi_out, lo_out
    );

    modport slave (
        input  md_valid, md_op, rs_val, rt_val,
        output busy, hi_out, lo_out
    );
endinterface

// File: rtl/mult_div_unit_compute.sv
// Combinational 64-bit result for the latched op; res_we is low when HI/LO must not change.
// MDU_MADD_EN adds the accumulate/subtract forms.
module md_compute
    import mdu_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_we
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic [63:0] res;
    logic [31:0] b_nz;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;

    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'd0, a} * {32'd0, b};
        acc    = {hi, lo};

        // Signed divide via magnitudes so the most-negative case never traps.
        b_nz  = (b == 32'd0) ? 32'd1 : b;
        a_mag = a[31] ? (~a + 32'd1) : a;
        b_mag = b_nz[31] ? (~b_nz + 32'd1) : b_nz;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        q_s   = (a[31] ^ b_nz[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;

        res    = acc;
        res_we = 1'b0;
        case (op)
            MULT: begin
                res    = prod_s;
                res_we = 1'b1;
            end
            MULTU: begin
                res    = prod_u;
                res_we = 1'b1;
            end
            DIV: begin
                res    = {r_s, q_s};
                res_we = (b != 32'd0);
            end
            DIVU: begin
                res    = {a % b_nz, a / b_nz};
                res_we = (b != 32'd0);
            end
`ifdef MDU_MADD_EN
            MADD: begin
                res    = acc + prod_s;
                res_we = 1'b1;
            end
            MADDU: begin
                res    = acc + prod_u;
                res_we = 1'b1;
            end
            MSUB: begin
                res    = acc - prod_s;
                res_we = 1'b1;
            end
            MSUBU: begin
                res    = acc - prod_u;
                res_we = 1'b1;
            end
`endif
            default: begin
                res    = acc;
                res_we = 1'b0;
            end
        endcase

        res_hi = res[63:32];
        res_lo = res[31:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; multi-cycle engine with registered busy.
// Macros: MDU_MADD_EN (madd/msub family), MDU_ISSUE_CHECK (sim check for issue while busy).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave md
);

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    md_op_t            op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              busy_q, busy_d;

    md_op_t            op_in;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    logic              res_we;

    md_compute u_compute (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .res_we (res_we)
    );

    always_comb begin
        op_in   = md_op_t'(md.md_op);
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (md.md_valid) begin
                    if (is_engine_op(op_in)) begin
                        op_d    = op_in;
                        a_d     = md.rs_val;
                        b_d     = md.rt_val;
                        cnt_d   = is_div_op(op_in) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else if (op_in == MTHI) begin
                        hi_d = md.rs_val;
                    end else if (op_in == MTLO) begin
                        lo_d = md.rs_val;
                    end
                end
            end
            RUN: begin
                // Issue during RUN is dropped; the counter only models latency.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (res_we) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign md.busy   = busy_q;
    assign md.hi_out = hi_q;
    assign md.lo_out = lo_q;

`ifdef MDU_ISSUE_CHECK
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(busy_q && md.md_valid))
                else $error("mult_div_unit: md_valid while busy");
        end
    end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences, random ops vs model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_unit_if bus ();

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] pre_hi, logic [31:0] pre_lo,
                                logic [31:0] exp_hi, logic [31:0] exp_lo,
                                int cyc, string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.pre_hi = pre_hi; v.pre_lo = pre_lo;
        v.exp_hi = exp_hi; v.exp_lo = exp_lo; v.cyc = cyc; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.md_valid = 1'b1;
        bus.md_op    = op;
        bus.rs_val   = a;
        bus.rt_val   = b;
        @(negedge clk);
        bus.md_valid = 1'b0;
        bus.md_op    = 4'd0;
        bus.rs_val   = $urandom;
        bus.rt_val   = $urandom;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cyc,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        issue(op, a, b);
        wait_idle(c);
        check({name, " busy_cycles"}, 32'(c), 32'(exp_cyc));
        check({name, " hi"}, bus.hi_out, exp_hi);
        check({name, " lo"}, bus.lo_out, exp_lo);
    endtask

    // Reference model straight from the architectural definition of each op.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
        longint          ps;
        longint unsigned pu;
        longint unsigned acc;
        ps  = longint'(int'(a)) * longint'(int'(b));
        pu  = longint'({32'd0, a}) * longint'({32'd0, b});
        acc = {hi, lo};
        cyc = 0;
        case (op)
            4'd1: begin {hi, lo} = ps; cyc = MC; end
            4'd2: begin {hi, lo} = pu; cyc = MC; end
            4'd3: begin
                cyc = DC;
                if (b != 0) begin
                    lo = int'(a) / int'(b);
                    hi = int'(a) % int'(b);
                end
            end
            4'd4: begin
                cyc = DC;
                if (b != 0) begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            4'd5: hi = a;
            4'd6: lo = a;
`ifdef MDU_MADD_EN
            4'd7:  begin {hi, lo} = acc + ps; cyc = MC; end
            4'd8:  begin {hi, lo} = acc + pu; cyc = MC; end
            4'd9:  begin {hi, lo} = acc - ps; cyc = MC; end
            4'd10: begin {hi, lo} = acc - pu; cyc = MC; end
`endif
            default: cyc = 0;
        endcase
    endtask

    initial begin
        logic [31:0] m_hi, m_lo, a, b;
        logic [3:0]  op;
        int          cyc, c;

        bus.md_valid = 1'b0;
        bus.md_op    = 4'd0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset hi", bus.hi_out, 32'd0);
        check("reset lo", bus.lo_out, 32'd0);
        reset = 1'b0;

        vq.push_back(mk(MULT,  32'hFFFFFFFD, 32'd7, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, MC, "mult_neg"));
        vq.push_back(mk(DIVU,  32'd100, 32'd7, 0, 0, 32'd2, 32'd14, DC, "divu_100_7"));
        vq.push_back(mk(DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, "div_m7_2"));
        vq.push_back(mk(DIV,   32'd7, 32'hFFFFFFFE, 0, 0, 32'd1, 32'hFFFFFFFD, DC, "div_7_m2"));
        vq.push_back(mk(DIV,   32'd5, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, DC, "div_by_zero"));
        vq.push_back(mk(DIVU,  32'd7, 32'd100, 0, 0, 32'd7, 32'd0, DC, "divu_small"));
        vq.push_back(mk(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, MC, "multu_max"));
        vq.push_back(mk(MTHI,  32'hDEADBEEF, 32'd0, 0, 32'h22, 32'hDEADBEEF, 32'h22, 0, "mthi"));
        vq.push_back(mk(MTLO,  32'h0BADF00D, 32'd9, 32'h33, 0, 32'h33, 32'h0BADF00D, 0, "mtlo"));
        vq.push_back(mk(MD_NONE, 32'h1, 32'h2, 32'h5, 32'h6, 32'h5, 32'h6, 0, "md_none"));
        vq.push_back(mk(4'd11, 32'h1, 32'h2, 32'h7, 32'h8, 32'h7, 32'h8, 0, "unknown_op"));
`ifdef MDU_MADD_EN
        vq.push_back(mk(MADDU, 32'd1, 32'd1, 0, 32'hFFFFFFFF, 32'd1, 32'd0, MC, "maddu_carry"));
        vq.push_back(mk(MSUB,  32'd2, 32'hFFFFFFFF, 0, 32'd5, 32'd0, 32'd7, MC, "msub_neg"));
`else
        vq.push_back(mk(MADDU, 32'd1, 32'd1, 0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 0, "maddu_off"));
        vq.push_back(mk(MSUB,  32'd2, 32'hFFFFFFFF, 0, 32'd5, 32'd0, 32'd5, 0, "msub_off"));
`endif

        foreach (vq[i]) begin
            issue(MTHI, vq[i].pre_hi, 32'd0);
            issue(MTLO, vq[i].pre_lo, 32'd0);
            run(vq[i].name, vq[i].op, vq[i].a, vq[i].b, vq[i].cyc, vq[i].exp_hi, vq[i].exp_lo);
        end

        // MTLO issued mid-run must be dropped.
        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'd0, 32'd0);
        issue(MULT, 32'd6, 32'd7);
        @(negedge clk);
        bus.md_valid = 1'b1;
        bus.md_op    = MTLO;
        bus.rs_val   = 32'h1234;
        @(negedge clk);
        bus.md_valid = 1'b0;
        bus.md_op    = 4'd0;
        wait_idle(c);
        check("mtlo_in_run busy_cycles", 32'(c), 32'(MC - 2));
        check("mtlo_in_run hi", bus.hi_out, 32'd0);
        check("mtlo_in_run lo", bus.lo_out, 32'd42);

        // Reset on the third busy cycle aborts with no later write.
        issue(MTHI, 32'hAAAA, 32'd0);
        issue(MTLO, 32'h5555, 32'd0);
        issue(MULTU, 32'hFFFFFFFF, 32'd2);
        @(negedge clk);
        @(negedge clk);
        check("abort busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort hi", bus.hi_out, 32'd0);
        check("abort lo", bus.lo_out, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort late hi", bus.hi_out, 32'd0);
        check("abort late lo", bus.lo_out, 32'd0);
        check("abort late busy", {31'd0, bus.busy}, 32'd0);

        // Random ops against the reference model.
        m_hi = $urandom;
        m_lo = $urandom;
        issue(MTHI, m_hi, 32'd0);
        issue(MTLO, m_lo, 32'd0);
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 11));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (op == 4'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            model(op, a, b, m_hi, m_lo, cyc);
            run($sformatf("rand%0d_op%0d", i, op), op, a, b, cyc, m_hi, m_lo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
